// File: rtl/geo_feeder.sv
// Streams six-point geofence test objects from point memory into a geofence
// consumer, collects one inside/outside result per object and tracks statistics.
module geo_feeder #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  num_obj,
  output logic [10:0] mem_addr,
  input  logic [30:0] mem_rdata,
  output logic        dut_rst,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  output logic [10:0] R,
  input  logic        valid,
  input  logic        is_inside,
  output logic        res_we,
  output logic [7:0]  res_addr,
  output logic        res_data,
  output logic [7:0]  inside_cnt,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, SEND, WAIT, DONE} state_t;

  state_t         state;
  logic [7:0]     num_lat;
  logic [7:0]     obj;
  logic [10:0]    base;
  logic [2:0]     step;
  logic [CW-1:0]  wait_cnt;
  logic [30:0]    buffer [6];

  // Single FSM; every output is registered. base tracks obj*6 incrementally,
  // and step counts LOAD (0..6) and SEND (0..5) cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      num_lat    <= '0;
      obj        <= '0;
      base       <= '0;
      step       <= '0;
      wait_cnt   <= '0;
      mem_addr   <= '0;
      dut_rst    <= 1'b0;
      X          <= '0;
      Y          <= '0;
      R          <= '0;
      res_we     <= 1'b0;
      res_addr   <= '0;
      res_data   <= 1'b0;
      inside_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < 6; i++) buffer[i] <= '0;
    end else begin
      res_we   <= 1'b0;
      res_addr <= '0;
      res_data <= 1'b0;
      done     <= 1'b0;
      dut_rst  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_lat    <= num_obj;
            obj        <= '0;
            base       <= '0;
            inside_cnt <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            step       <= '0;
            mem_addr   <= '0;
            if (num_obj == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        // Read data lags the address by one cycle, so buffer[step-1] is
        // captured while mem_addr already points at the next word.
        LOAD: begin
          if (step != 3'd0) buffer[step - 3'd1] <= mem_rdata;
          if (step == 3'd6) begin
            state    <= KICK;
            dut_rst  <= 1'b1;
            mem_addr <= '0;
          end else begin
            step     <= step + 3'd1;
            mem_addr <= (step == 3'd5) ? 11'd0 : mem_addr + 11'd1;
          end
        end
        KICK: begin
          state       <= SEND;
          step        <= '0;
          {X, Y, R}   <= buffer[0];
        end
        SEND: begin
          if (step == 3'd5) begin
            state    <= WAIT;
            wait_cnt <= '0;
            X        <= '0;
            Y        <= '0;
            R        <= '0;
          end else begin
            step      <= step + 3'd1;
            {X, Y, R} <= buffer[step + 3'd1];
          end
        end
        // A valid arriving in the final counted cycle still wins over timeout.
        WAIT: begin
          if (valid || wait_cnt == CW'(TIMEOUT - 1)) begin
            res_we   <= 1'b1;
            res_addr <= obj;
            res_data <= valid & is_inside;
            if (valid && is_inside) inside_cnt <= inside_cnt + 8'd1;
            if (!valid) err <= 1'b1;
            obj  <= obj + 8'd1;
            base <= base + 11'd6;
            if (obj + 8'd1 == num_lat) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= LOAD;
              step     <= '0;
              mem_addr <= base + 11'd6;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_geo_feeder.sv
// Scoreboard bench for geo_feeder: memory and consumer models, expected points,
// results and completion stats queued at start and checked as the DUT emits them.
module tb_geo_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_obj;
  logic [10:0] mem_addr;
  logic [30:0] mem_rdata;
  logic        dut_rst;
  logic [9:0]  X;
  logic [9:0]  Y;
  logic [10:0] R;
  logic        valid;
  logic        is_inside;
  logic        res_we;
  logic [7:0]  res_addr;
  logic        res_data;
  logic [7:0]  inside_cnt;
  logic        busy;
  logic        done;
  logic        err;

  logic cons_valid = 1'b0;
  logic cons_inside = 1'b0;
  logic stray_valid = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_target = 0;
  int kick_cyc = -100;
  int fire_cyc = -100;
  int pt_idx = 0;
  bit cons_en = 1'b0;

  logic [30:0] exp_pts[$];
  logic [8:0]  exp_res[$];
  int          exp_res_cyc[$];
  logic [8:0]  exp_done[$];
  logic        cons_q[$];

  assign valid     = cons_valid | stray_valid;
  assign is_inside = stray_valid ? 1'b1 : cons_inside;

  geo_feeder #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .num_obj(num_obj),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .dut_rst(dut_rst),
    .X(X), .Y(Y), .R(R), .valid(valid), .is_inside(is_inside),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .inside_cnt(inside_cnt), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] point_word(input int addr);
    logic [9:0]  px;
    logic [9:0]  py;
    logic [10:0] pr;
    px = 10'(addr + 1);
    py = 10'(addr * 3 + 7);
    pr = 11'(addr * 5 + 1);
    return {px, py, pr};
  endfunction

  // Point memory with one cycle of read latency
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mem_rdata <= point_word(int'(mem_addr));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Monitor and consumer model; answers 10 cycles after the last SEND point
  always @(negedge clk) begin
    if (reset) begin
      pt_idx     = 0;
      fire_cyc   = -100;
      cons_valid = 1'b0;
      exp_pts.delete();
      exp_res.delete();
      exp_res_cyc.delete();
      exp_done.delete();
      cons_q.delete();
    end else begin
      if (cyc == fire_cyc) begin
        cons_valid  = 1'b1;
        cons_inside = (cons_q.size() > 0) ? cons_q.pop_front() : 1'b0;
      end else if (cyc == fire_cyc + 1) begin
        cons_valid = 1'b0;
        fire_cyc   = -100;
      end
      if (dut_rst) kick_cyc = cyc;
      if ({X, Y, R} != 31'd0) begin
        if (exp_pts.size() > 0) checkOutput("point", 32'({X, Y, R}), 32'(exp_pts.pop_front()));
        else checkOutput("spurious_point", 32'({X, Y, R}), 32'd0);
        if (pt_idx == 0) checkOutput("kick_to_point0", 32'(cyc - kick_cyc), 32'd1);
        pt_idx++;
        if (pt_idx == 6) begin
          pt_idx = 0;
          if (cons_en) begin
            fire_cyc = cyc + 10;
            exp_res_cyc.push_back(cyc + 11);
          end else begin
            exp_res_cyc.push_back(cyc + 16);
          end
        end
      end
      if (res_we) begin
        if (exp_res.size() > 0) begin
          checkOutput("res_addr_data", 32'({res_addr, res_data}), 32'(exp_res.pop_front()));
          if (exp_res_cyc.size() > 0) checkOutput("res_cycle", 32'(cyc), 32'(exp_res_cyc.pop_front()));
        end else begin
          checkOutput("spurious_res_we", 32'(res_we), 32'd0);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() > 0) checkOutput("inside_cnt_err", 32'({inside_cnt, err}), 32'(exp_done.pop_front()));
        else checkOutput("spurious_done", 32'(done), 32'd0);
      end
    end
  end

  task automatic applyStimulus(input int n, input logic [7:0] pattern, input bit consumer_on);
    int cnt = 0;
    cons_en = consumer_on;
    for (int o = 0; o < n; o++) begin
      for (int k = 0; k < 6; k++) exp_pts.push_back(point_word(o * 6 + k));
      exp_res.push_back({8'(o), consumer_on & pattern[o]});
      if (consumer_on) cons_q.push_back(pattern[o]);
      if (consumer_on && pattern[o]) cnt++;
    end
    exp_done.push_back({8'(cnt), (!consumer_on && n > 0)});
    done_target++;
    @(negedge clk);
    start     = 1'b1;
    num_obj   = 8'(n);
    start_cyc = cyc;
    @(negedge clk);
    start   = 1'b0;
    num_obj = 8'd0;
  endtask

  task automatic waitDone();
    int budget = 2000;
    while (done_cnt < done_target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("done_count", 32'(done_cnt), 32'(done_target));
    @(negedge clk);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("queues_drained", 32'(exp_pts.size() + exp_res.size() + exp_done.size()), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    num_obj = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", 32'({busy, done, res_we, dut_rst, err}), 32'd0);
    checkOutput("reset_xyr", 32'({X, Y, R}), 32'd0);
    checkOutput("reset_addr_cnt", 32'({mem_addr, inside_cnt, res_addr}), 32'd0);
    reset = 1'b0;

    // Single object, inside
    applyStimulus(1, 8'b1, 1'b1);
    checkOutput("busy_running", 32'(busy), 32'd1);
    waitDone();

    // Three objects 1,0,1 with a start pulse while busy
    applyStimulus(3, 8'b101, 1'b1);
    repeat (20) @(negedge clk);
    start   = 1'b1;
    num_obj = 8'd9;
    @(negedge clk);
    start   = 1'b0;
    num_obj = 8'd0;
    waitDone();

    // Stray valid during LOAD and SEND must not produce a result
    applyStimulus(1, 8'b0, 1'b1);
    while (cyc < start_cyc + 3) @(negedge clk);
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    while (cyc < start_cyc + 11) @(negedge clk);
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    waitDone();

    // Timeout: consumer silent
    applyStimulus(1, 8'b0, 1'b0);
    waitDone();

    // Zero objects: done one cycle after start, err cleared
    applyStimulus(0, 8'b0, 1'b1);
    checkOutput("zero_obj_done", 32'(done), 32'd1);
    checkOutput("zero_obj_addr", 32'(mem_addr), 32'd0);
    waitDone();

    // Reset while point 3 is on X/Y/R
    applyStimulus(1, 8'b1, 1'b1);
    done_target--;
    while (cyc < start_cyc + 12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_xyr", 32'({X, Y, R}), 32'd0);
    checkOutput("rst_busy_res_done", 32'({busy, res_we, done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("rst_no_done", 32'(done_cnt), 32'(done_target));
    applyStimulus(1, 8'b1, 1'b1);
    waitDone();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/geo_feeder.md
GEO_FEEDER -- requirements
Module: geo_feeder

Interface
REQ-001 Parameters: TIMEOUT, default 1023, maximum cycles to wait for consumer valid per object.
REQ-002 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-003 Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to process a test set
- num_obj  in  8  number of objects in the set, sampled with start
- mem_addr  out  11  point memory address
- mem_rdata  in  31  point word {X[30:21], Y[20:11], R[10:0]}, valid one cycle after mem_addr
- dut_rst  out  1  restart pulse to the geofence consumer
- X  out  10  point X to consumer
- Y  out  10  point Y to consumer
- R  out  11  point radius to consumer
- valid  in  1  consumer result strobe
- is_inside  in  1  consumer result, qualified by valid
- res_we  out  1  result write strobe
- res_addr  out  8  object index of result
- res_data  out  1  captured is_inside, 0 on timeout
- inside_cnt  out  8  running count of inside results
- busy  out  1  set processing
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: at least one object timed out

Function
REQ-004 States SHALL be IDLE, LOAD, KICK, SEND, WAIT, DONE.
REQ-005 IDLE: start=1 latches num_obj, clears obj index, inside_cnt and err, goes to LOAD; num_obj=0 goes to DONE.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 LOAD: mem_addr = obj*6+k for k=0..5 on consecutive cycles; each mem_rdata written to a 6-entry buffer one cycle later; LOAD lasts exactly 7 cycles, then KICK.
REQ-008 KICK: dut_rst=1 for exactly one cycle, then SEND.
REQ-009 SEND: six consecutive cycles; cycle i drives buffer[i] on X/Y/R (point 0 in the cycle right after KICK); then WAIT.
REQ-010 Outside SEND, X, Y and R SHALL be 0.
REQ-011 WAIT: a cycle counter runs from 0; valid=1 ends the wait; counter reaching TIMEOUT with no valid also ends the wait.
REQ-012 On valid in WAIT: res_we=1 for the next cycle with res_addr=obj, res_data=is_inside; inside_cnt increments when is_inside=1.
REQ-013 On timeout: res_we=1 with res_data=0 and err set; inside_cnt unchanged.
REQ-014 valid outside WAIT SHALL be ignored.
REQ-015 After a result: obj increments; if obj equals the latched num_obj, go to DONE, otherwise go to LOAD.
REQ-016 DONE: done=1 for one cycle, then IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 Address math SHALL be 11-bit unsigned; the maximum is 254*6+5 = 1529, so no wrap.
REQ-019 inside_cnt SHALL be 8-bit and SHALL NOT wrap, because it is at most 255.

Reset
REQ-020 reset=1 at any point, including mid-object, SHALL force IDLE on the next edge, with:
- all outputs 0
- buffer, obj index, wait counter, inside_cnt and err cleared
- no res_we and no done emitted for the aborted set

Verification
REQ-021 Single object:
- stimulus: num_obj=1, start; consumer returns valid with is_inside=1 ten cycles after the last SEND cycle
- response: mem_addr 0..5; dut_rst one cycle after LOAD; points 0..5 on X/Y/R in order; res_we with res_addr=0, res_data=1; inside_cnt=1; done pulse; err=0
REQ-022 Three objects returning is_inside 1, 0, 1:
- mem_addr sequence 0..17
- three res_we pulses with res_addr 0, 1, 2
- inside_cnt=2, single done
REQ-023 Timeout:
- stimulus: TIMEOUT=15, consumer never asserts valid
- response: res_we with res_data=0 exactly 15 cycles into WAIT; err=1
REQ-024 Start handling:
- num_obj=0 with start -> done one cycle later; no mem_addr activity
- start pulsed while busy -> no effect on the running set
REQ-025 Reset mid-SEND:
- stimulus: reset asserted at point 3
- response: X/Y/R=0 next cycle, busy=0, no res_we or done
- a fresh start afterwards processes object 0 from address 0
REQ-026 Stray valid:
- stimulus: valid asserted during LOAD and SEND
- response: no res_we; result taken only from valid in WAIT
